// File: rtl/irq_arbiter.sv
// Machine-mode interrupt front end: edge capture, masking,
// fixed-priority selection and req/ack/complete handshake.
module irq_arbiter #(
  parameter int NUM_IRQ    = 64,
  parameter int CAUSE_BASE = 16,
  parameter int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               global_ie,
  input  logic               irq_ack,
  input  logic               irq_complete,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_cause,
  output logic               irq_active,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NUM_IRQ-1:0]  prev_q;
  logic [NUM_IRQ-1:0]  pend_q;
  logic [NUM_IRQ-1:0]  pend_d;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  clr;
  logic [NUM_IRQ-1:0]  elig;
  logic                any_elig;
  logic [ID_W-1:0]     sel;
  logic                req_q;
  logic                req_d;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     id_d;
  logic                act_q;
  logic                act_d;
  logic                take_ack;

  assign rise     = irq_lines & ~prev_q;
  assign take_ack = (state_q == REQ) && irq_ack;
  assign clr      = take_ack ? (NUM_IRQ'(1) << id_q) : '0;
  // a fresh edge on the line being acked wins over the clear
  assign pend_d   = (pend_q & ~clr) | rise;

  assign elig     = pend_q & irq_enable & {NUM_IRQ{global_ie}};
  assign any_elig = |elig;

  // scan downward so the lowest set index is left in sel
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = sel;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = ACTIVE;
          req_d   = 1'b0;
          act_d   = 1'b1;
        end
      end
      ACTIVE: begin
        if (irq_complete) begin
          state_d = IDLE;
          act_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        act_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '1;
      pend_q  <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_lines;
      pend_q  <= pend_d;
      req_q   <= req_d;
      id_q    <= id_d;
      act_q   <= act_d;
    end
  end

  assign irq_req     = req_q;
  assign irq_id      = id_q;
  assign irq_active  = act_q;
  assign irq_pending = pend_q;
  assign irq_cause   = {1'b1, 31'(CAUSE_BASE) + 31'(id_q)};

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: latency, priority, masking,
// re-fire during handler and reset behaviour.
module tb_irq_arbiter;

  localparam int N = 64;
  localparam int W = 6;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  irq_lines;
  logic [N-1:0]  irq_enable;
  logic          global_ie;
  logic          irq_ack;
  logic          irq_complete;
  logic          irq_req;
  logic [W-1:0]  irq_id;
  logic [31:0]   irq_cause;
  logic          irq_active;
  logic [N-1:0]  irq_pending;

  int checks = 0;
  int errors = 0;

  irq_arbiter #(.NUM_IRQ(N), .CAUSE_BASE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_lines    (irq_lines),
    .irq_enable   (irq_enable),
    .global_ie    (global_ie),
    .irq_ack      (irq_ack),
    .irq_complete (irq_complete),
    .irq_req      (irq_req),
    .irq_id       (irq_id),
    .irq_cause    (irq_cause),
    .irq_active   (irq_active),
    .irq_pending  (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_cmp();
    irq_complete = 1'b1;
    tick();
    irq_complete = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    irq_lines    = '0;
    irq_enable   = '1;
    global_ie    = 1'b1;
    irq_ack      = 1'b0;
    irq_complete = 1'b0;
    tick();
    tick();
    chk("rst_req", 64'(irq_req), 64'h0);
    chk("rst_id", 64'(irq_id), 64'h0);
    chk("rst_cause", 64'(irq_cause), 64'h8000_0010);
    chk("rst_active", 64'(irq_active), 64'h0);
    chk("rst_pend", irq_pending, 64'h0);
    rst_n = 1'b1;
    tick();

    // T1
    irq_lines[5] = 1'b1;
    tick();
    chk("t1_pend", irq_pending, 64'h20);
    chk("t1_req_early", 64'(irq_req), 64'h0);
    tick();
    chk("t1_req", 64'(irq_req), 64'h1);
    chk("t1_id", 64'(irq_id), 64'd5);
    chk("t1_cause", 64'(irq_cause), 64'h8000_0015);
    pulse_cmp();
    chk("t1_cmp_in_req", 64'(irq_req), 64'h1);
    pulse_ack();
    chk("t1_act", 64'(irq_active), 64'h1);
    chk("t1_req_off", 64'(irq_req), 64'h0);
    chk("t1_pend_clr", irq_pending, 64'h0);
    pulse_ack();
    chk("t1_ack_in_act", 64'(irq_active), 64'h1);
    pulse_cmp();
    chk("t1_done_act", 64'(irq_active), 64'h0);
    tick();
    chk("t1_idle_req", 64'(irq_req), 64'h0);
    irq_lines = '0;
    tick();

    // T2
    irq_lines[3]  = 1'b1;
    irq_lines[40] = 1'b1;
    tick();
    tick();
    chk("t2_req", 64'(irq_req), 64'h1);
    chk("t2_id3", 64'(irq_id), 64'd3);
    irq_ack      = 1'b1;
    irq_complete = 1'b1;
    tick();
    irq_ack      = 1'b0;
    irq_complete = 1'b0;
    chk("t2_ackcmp_act", 64'(irq_active), 64'h1);
    chk("t2_pend40", irq_pending, 64'h100_0000_0000);
    pulse_cmp();
    chk("t2_req_gap", 64'(irq_req), 64'h0);
    tick();
    chk("t2_id40", 64'(irq_id), 64'd40);
    chk("t2_req40", 64'(irq_req), 64'h1);
    chk("t2_cause40", 64'(irq_cause), 64'h8000_0038);
    pulse_ack();
    pulse_cmp();
    irq_lines = '0;
    tick();

    // T3
    global_ie    = 1'b0;
    irq_lines[7] = 1'b1;
    tick();
    chk("t3_pend", irq_pending, 64'h80);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_noreq", 64'(irq_req), 64'h0);
    end
    global_ie = 1'b1;
    tick();
    chk("t3_req", 64'(irq_req), 64'h1);
    chk("t3_id", 64'(irq_id), 64'd7);
    pulse_ack();
    pulse_cmp();
    irq_lines = '0;
    tick();

    // T4
    irq_enable[9] = 1'b0;
    irq_lines[9]  = 1'b1;
    tick();
    tick();
    chk("t4_pend", irq_pending, 64'h200);
    chk("t4_noreq", 64'(irq_req), 64'h0);
    irq_enable[9] = 1'b1;
    tick();
    chk("t4_req", 64'(irq_req), 64'h1);
    chk("t4_id", 64'(irq_id), 64'd9);
    global_ie = 1'b0;
    tick();
    tick();
    chk("t4_hold", 64'(irq_req), 64'h1);
    pulse_ack();
    chk("t4_act", 64'(irq_active), 64'h1);
    global_ie = 1'b1;
    pulse_cmp();
    irq_lines = '0;
    tick();

    // T5
    irq_lines[2] = 1'b1;
    tick();
    tick();
    chk("t5_id", 64'(irq_id), 64'd2);
    irq_lines[2] = 1'b0;
    pulse_ack();
    chk("t5_act", 64'(irq_active), 64'h1);
    irq_lines[2] = 1'b1;
    tick();
    chk("t5_repend", irq_pending, 64'h4);
    tick();
    chk("t5_nonest", 64'(irq_req), 64'h0);
    pulse_cmp();
    chk("t5_idle", 64'(irq_active), 64'h0);
    tick();
    chk("t5_req2", 64'(irq_req), 64'h1);
    chk("t5_id2", 64'(irq_id), 64'd2);
    pulse_ack();
    pulse_cmp();
    irq_lines = '0;
    tick();

    // T6
    irq_lines[12] = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_noreq", 64'(irq_req), 64'h0);
    chk("t6_nopend", irq_pending, 64'h0);
    irq_lines[20] = 1'b1;
    tick();
    tick();
    chk("t6_req20", 64'(irq_req), 64'h1);
    chk("t6_id20", 64'(irq_id), 64'd20);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_req", 64'(irq_req), 64'h0);
    chk("t6_rst_pend", irq_pending, 64'h0);
    chk("t6_rst_id", 64'(irq_id), 64'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_after", 64'(irq_req), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
